// File: rtl/wb_pkg.sv
// Shared widths and FSM state type for the Wishbone slave decoder.
package wb_pkg;

  localparam int unsigned BusWidth = 32;
  localparam int unsigned SelWidth = BusWidth / 8;
  localparam int unsigned CntWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } wb_state_e;

endpackage

// File: rtl/wb_slave_decoder_if.sv
// Master-side and slave-side bus signals of the Wishbone slave decoder.
interface wb_slave_decoder_if
  import wb_pkg::*;
#(
  parameter int unsigned NumSlaves = 4
) ();

  logic                          wb_cyc_i;
  logic                          wb_stb_i;
  logic                          wb_we_i;
  logic [SelWidth-1:0]           wb_sel_i;
  logic [BusWidth-1:0]           wb_adr_i;
  logic [BusWidth-1:0]           wb_dat_i;
  logic [BusWidth-1:0]           wb_dat_o;
  logic                          wb_ack_o;
  logic                          wb_err_o;

  logic [NumSlaves-1:0]          slv_cyc_o;
  logic [NumSlaves-1:0]          slv_stb_o;
  logic                          slv_we_o;
  logic [SelWidth-1:0]           slv_sel_o;
  logic [BusWidth-1:0]           slv_adr_o;
  logic [BusWidth-1:0]           slv_dat_o;
  logic [BusWidth*NumSlaves-1:0] slv_dat_i;
  logic [NumSlaves-1:0]          slv_ack_i;
  logic [NumSlaves-1:0]          slv_err_i;

  // View of the decoder itself.
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output slv_cyc_o, slv_stb_o, slv_we_o, slv_sel_o, slv_adr_o, slv_dat_o,
    input  slv_dat_i, slv_ack_i, slv_err_i
  );

  // View of the environment driving the upstream master and downstream slaves.
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  slv_cyc_o, slv_stb_o, slv_we_o, slv_sel_o, slv_adr_o, slv_dat_o,
    output slv_dat_i, slv_ack_i, slv_err_i
  );

endinterface

// File: rtl/wb_addr_decode.sv
// Combinational window decode: range check of a byte address and one-hot slave select.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter logic [BusWidth-1:0] BaseAddr    = '0,
  parameter int unsigned         SlvAddrBits = 8,
  parameter int unsigned         NumSlaves   = 4
) (
  input  logic [BusWidth-1:0]  adr_i,
  output logic                 in_range_o,
  output logic [NumSlaves-1:0] onehot_o
);

  logic [BusWidth-1:0] offset;
  logic [BusWidth-1:0] index;

  always_comb begin
    offset     = adr_i - BaseAddr;
    index      = offset >> SlvAddrBits;
    // The >= test rejects addresses below the base that would wrap to a small index.
    in_range_o = (adr_i >= BaseAddr) && (index < BusWidth'(NumSlaves));
    for (int unsigned k = 0; k < NumSlaves; k++) begin
      onehot_o[k] = in_range_o && (index == BusWidth'(k));
    end
  end

endmodule

// File: rtl/wb_slave_decoder.sv
// Wishbone 1-to-N address decoder: registered slave strobes, timeout and error counting.
module wb_slave_decoder
  import wb_pkg::*;
#(
  parameter logic [BusWidth-1:0] C_BASEADDR      = 32'h0000_0000,
  parameter int unsigned         C_SLV_ADDR_BITS = 8,
  parameter int unsigned         C_NUM_SLAVES    = 4,
  parameter int unsigned         C_TIMEOUT       = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  wb_slave_decoder_if.slave   bus,
  output logic [CntWidth-1:0] err_count_o
);

  localparam int unsigned TmoWidth = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(C_TIMEOUT - 1);

  wb_state_e             state_q, state_d;
  logic [C_NUM_SLAVES-1:0] slv_oh_q, slv_oh_d;
  logic [TmoWidth-1:0]   tmo_q, tmo_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [BusWidth-1:0]   rdat_q, rdat_d;
  logic [CntWidth-1:0]   err_cnt_q, err_cnt_d;
  logic                  we_q;
  logic [SelWidth-1:0]   sel_q;
  logic [BusWidth-1:0]   adr_q;
  logic [BusWidth-1:0]   dat_q;
  logic                  load_req;
  logic                  err_inc;

  logic                    dec_in_range;
  logic [C_NUM_SLAVES-1:0] dec_onehot;
  logic                    hit_ack;
  logic                    hit_err;
  logic [BusWidth-1:0]     sel_rdata;

  wb_addr_decode #(
    .BaseAddr    (C_BASEADDR),
    .SlvAddrBits (C_SLV_ADDR_BITS),
    .NumSlaves   (C_NUM_SLAVES)
  ) u_addr_decode (
    .adr_i      (bus.wb_adr_i),
    .in_range_o (dec_in_range),
    .onehot_o   (dec_onehot)
  );

  // Responses only count from the slave currently being strobed.
  assign hit_ack = |(bus.slv_ack_i & slv_oh_q);
  assign hit_err = |(bus.slv_err_i & slv_oh_q);

  always_comb begin
    sel_rdata = '0;
    for (int unsigned k = 0; k < C_NUM_SLAVES; k++) begin
      if (slv_oh_q[k]) begin
        sel_rdata = bus.slv_dat_i[BusWidth*k +: BusWidth];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    slv_oh_d = slv_oh_q;
    tmo_d    = tmo_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdat_d   = '0;
    load_req = 1'b0;
    err_inc  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          if (dec_in_range) begin
            state_d  = StAccess;
            slv_oh_d = dec_onehot;
            tmo_d    = '0;
            load_req = 1'b1;
          end else begin
            state_d = StResp;
            err_d   = 1'b1;
            err_inc = 1'b1;
          end
        end
      end
      StAccess: begin
        if (!bus.wb_cyc_i) begin
          state_d  = StIdle;
          slv_oh_d = '0;
        end else if (hit_err) begin
          state_d  = StResp;
          slv_oh_d = '0;
          err_d    = 1'b1;
        end else if (hit_ack) begin
          state_d  = StResp;
          slv_oh_d = '0;
          ack_d    = 1'b1;
          rdat_d   = sel_rdata;
        end else if (tmo_q == TmoLast) begin
          state_d  = StResp;
          slv_oh_d = '0;
          err_d    = 1'b1;
          err_inc  = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d  = StIdle;
        slv_oh_d = '0;
      end
    endcase

    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= StIdle;
      slv_oh_q  <= '0;
      tmo_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdat_q    <= '0;
      err_cnt_q <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      slv_oh_q  <= slv_oh_d;
      tmo_q     <= tmo_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdat_q    <= rdat_d;
      err_cnt_q <= err_cnt_d;
      if (load_req) begin
        we_q  <= bus.wb_we_i;
        sel_q <= bus.wb_sel_i;
        adr_q <= bus.wb_adr_i;
        dat_q <= bus.wb_dat_i;
      end
    end
  end

  assign bus.slv_cyc_o = slv_oh_q;
  assign bus.slv_stb_o = slv_oh_q;
  assign bus.slv_we_o  = we_q;
  assign bus.slv_sel_o = sel_q;
  assign bus.slv_adr_o = adr_q;
  assign bus.slv_dat_o = dat_q;
  assign bus.wb_ack_o  = ack_q;
  assign bus.wb_err_o  = err_q;
  assign bus.wb_dat_o  = rdat_q;
  assign err_count_o   = err_cnt_q;

endmodule
